mmc_rd_return_buffer: RTL and testbench

//  Per-channel read-return stage between the DFI SDR return path and the MRC read consumer.

---
 rtl/mmc_rd_return_buffer.sv | 196 +++++++++++++++++++
 tb/tb_mmc_rd_return_buffer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmc_rd_return_buffer.sv
// Read-return buffer for one DFI channel: pairs each returning beat with the oldest issued
// read tag, buffers the tagged beats, and meters read-issue credit so the buffer never overflows.
module mmc_rd_return_buffer #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 4,
    parameter int TAG_W     = 4,
    parameter int DEPTH     = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic                          clk,
    input  logic                          reset_poweron,

    input  logic                          mmc__rbuf__rd_issue,
    input  logic [TAG_W-1:0]              mmc__rbuf__rd_tag,
    output logic                          rbuf__mmc__rd_ready,

    input  logic                          dfi__mmc__valid,
    input  logic [WORD_W*NUM_WORDS-1:0]   dfi__mmc__data,

    output logic                          rbuf__mrc__valid,
    output logic [TAG_W-1:0]              rbuf__mrc__tag,
    output logic [WORD_W*NUM_WORDS-1:0]   rbuf__mrc__data,
    input  logic                          mrc__rbuf__ready,

    output logic [$clog2(DEPTH):0]        rbuf__outstanding,
    output logic                          rbuf__err_orphan,
    output logic                          rbuf__err_overflow,
    output logic                          rbuf__err_timeout
);

    localparam int DATA_W  = WORD_W * NUM_WORDS;
    localparam int ENTRY_W = TAG_W + DATA_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int TMO_W   = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [TMO_W-1:0] TIMEOUT_C = TMO_W'(TIMEOUT);

    // Tag FIFO state
    logic [TAG_W-1:0]   tag_mem_q [DEPTH];
    logic [PTR_W-1:0]   tag_wr_ptr_q, tag_wr_ptr_d;
    logic [PTR_W-1:0]   tag_rd_ptr_q, tag_rd_ptr_d;
    logic [CNT_W-1:0]   tag_cnt_q,    tag_cnt_d;

    // Data FIFO state
    logic [ENTRY_W-1:0] data_mem_q [DEPTH];
    logic [PTR_W-1:0]   data_wr_ptr_q, data_wr_ptr_d;
    logic [PTR_W-1:0]   data_rd_ptr_q, data_rd_ptr_d;
    logic [CNT_W-1:0]   data_cnt_q,    data_cnt_d;

    // Timeout and sticky error state
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               err_orphan_q,   err_orphan_d;
    logic               err_overflow_q, err_overflow_d;
    logic               err_timeout_q,  err_timeout_d;

    // Per-cycle control
    logic [CNT_W:0]     credit_sum;
    logic               rd_ready;
    logic               tag_push;
    logic               tag_avail;
    logic               tag_pop;
    logic [TAG_W-1:0]   ret_tag;
    logic               data_full;
    logic               out_valid;
    logic               data_pop;
    logic               data_push;
    logic [ENTRY_W-1:0] head_entry;

    // Credit counts every read that still owns a slot, whether in flight or buffered.
    always_comb begin
        credit_sum = {1'b0, tag_cnt_q} + {1'b0, data_cnt_q};
        rd_ready   = credit_sum < {1'b0, DEPTH_C};
    end

    always_comb begin
        tag_push  = mmc__rbuf__rd_issue & rd_ready;
        tag_avail = (tag_cnt_q != '0);
        tag_pop   = dfi__mmc__valid & tag_avail;
        ret_tag   = tag_avail ? tag_mem_q[tag_rd_ptr_q] : '0;
    end

    // A full FIFO still accepts the return when the consumer frees a slot this cycle.
    always_comb begin
        data_full  = (data_cnt_q == DEPTH_C);
        out_valid  = (data_cnt_q != '0);
        data_pop   = out_valid & mrc__rbuf__ready;
        data_push  = dfi__mmc__valid & (~data_full | data_pop);
        head_entry = data_mem_q[data_rd_ptr_q];
    end

    always_comb begin
        tag_wr_ptr_d = tag_wr_ptr_q;
        tag_rd_ptr_d = tag_rd_ptr_q;
        tag_cnt_d    = tag_cnt_q;
        if (tag_push) begin
            tag_wr_ptr_d = tag_wr_ptr_q + 1'b1;
        end
        if (tag_pop) begin
            tag_rd_ptr_d = tag_rd_ptr_q + 1'b1;
        end
        case ({tag_push, tag_pop})
            2'b10:   tag_cnt_d = tag_cnt_q + 1'b1;
            2'b01:   tag_cnt_d = tag_cnt_q - 1'b1;
            default: tag_cnt_d = tag_cnt_q;
        endcase
    end

    always_comb begin
        data_wr_ptr_d = data_wr_ptr_q;
        data_rd_ptr_d = data_rd_ptr_q;
        data_cnt_d    = data_cnt_q;
        if (data_push) begin
            data_wr_ptr_d = data_wr_ptr_q + 1'b1;
        end
        if (data_pop) begin
            data_rd_ptr_d = data_rd_ptr_q + 1'b1;
        end
        case ({data_push, data_pop})
            2'b10:   data_cnt_d = data_cnt_q + 1'b1;
            2'b01:   data_cnt_d = data_cnt_q - 1'b1;
            default: data_cnt_d = data_cnt_q;
        endcase
    end

    // Age of the oldest outstanding read; any return restarts the measurement.
    always_comb begin
        if (!tag_avail || dfi__mmc__valid) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TIMEOUT_C) begin
            tmo_cnt_d = tmo_cnt_q;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_comb begin
        err_orphan_d   = err_orphan_q   | (dfi__mmc__valid & ~tag_avail);
        err_overflow_d = err_overflow_q | (dfi__mmc__valid & data_full & ~data_pop);
        err_timeout_d  = err_timeout_q  | (tmo_cnt_q == TIMEOUT_C);
    end

    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            tag_wr_ptr_q   <= '0;
            tag_rd_ptr_q   <= '0;
            tag_cnt_q      <= '0;
            data_wr_ptr_q  <= '0;
            data_rd_ptr_q  <= '0;
            data_cnt_q     <= '0;
            tmo_cnt_q      <= '0;
            err_orphan_q   <= 1'b0;
            err_overflow_q <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            tag_wr_ptr_q   <= tag_wr_ptr_d;
            tag_rd_ptr_q   <= tag_rd_ptr_d;
            tag_cnt_q      <= tag_cnt_d;
            data_wr_ptr_q  <= data_wr_ptr_d;
            data_rd_ptr_q  <= data_rd_ptr_d;
            data_cnt_q     <= data_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            err_orphan_q   <= err_orphan_d;
            err_overflow_q <= err_overflow_d;
            err_timeout_q  <= err_timeout_d;
        end
    end

    // Storage arrays need no reset: the pointers and counts define what is live.
    always_ff @(posedge clk) begin
        if (tag_push) begin
            tag_mem_q[tag_wr_ptr_q] <= mmc__rbuf__rd_tag;
        end
        if (data_push) begin
            data_mem_q[data_wr_ptr_q] <= {ret_tag, dfi__mmc__data};
        end
    end

    always_comb begin
        rbuf__mmc__rd_ready = rd_ready;
        rbuf__mrc__valid    = out_valid;
        rbuf__mrc__tag      = out_valid ? head_entry[ENTRY_W-1:DATA_W] : '0;
        rbuf__mrc__data     = out_valid ? head_entry[DATA_W-1:0]       : '0;
        rbuf__outstanding   = tag_cnt_q;
        rbuf__err_orphan    = err_orphan_q;
        rbuf__err_overflow  = err_overflow_q;
        rbuf__err_timeout   = err_timeout_q;
    end

    a_issue_needs_credit : assert property (
        @(posedge clk) disable iff (reset_poweron)
        mmc__rbuf__rd_issue |-> rbuf__mmc__rd_ready
    );

endmodule

// File: tb/tb_mmc_rd_return_buffer.sv
// Scoreboard bench for mmc_rd_return_buffer: a queue-based reference model predicts tagged
// beats, credit, occupancy and sticky errors; a negedge monitor checks every accepted beat.
module tb_mmc_rd_return_buffer;

    localparam int DW      = 128;
    localparam int TW      = 4;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          issue = 1'b0;
    logic [TW-1:0] tag_i = '0;
    logic          rd_ready_o;
    logic          dv = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          v_o;
    logic [TW-1:0] t_o;
    logic [DW-1:0] d_o;
    logic          rdy = 1'b0;
    logic [3:0]    outst_o;
    logic          orph_o, ovf_o, tmo_o;

    mmc_rd_return_buffer dut (
        .clk                 (clk),
        .reset_poweron       (rst),
        .mmc__rbuf__rd_issue (issue),
        .mmc__rbuf__rd_tag   (tag_i),
        .rbuf__mmc__rd_ready (rd_ready_o),
        .dfi__mmc__valid     (dv),
        .dfi__mmc__data      (data_i),
        .rbuf__mrc__valid    (v_o),
        .rbuf__mrc__tag      (t_o),
        .rbuf__mrc__data     (d_o),
        .mrc__rbuf__ready    (rdy),
        .rbuf__outstanding   (outst_o),
        .rbuf__err_orphan    (orph_o),
        .rbuf__err_overflow  (ovf_o),
        .rbuf__err_timeout   (tmo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] tag;
        logic [DW-1:0] data;
    } beat_t;

    beat_t         exp_q[$];
    logic [TW-1:0] mtags[$];
    int            mdata = 0;
    int            mtmo  = 0;
    bit            e_orph = 0, e_ovf = 0, e_tmo = 0;
    int            checks = 0;
    int            errors = 0;
    beat_t         mon_b;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic bit model_ready();
        return (mtags.size() + mdata) < DEPTH;
    endfunction

    // Every beat the consumer accepts must be the oldest predicted one.
    always @(negedge clk) begin
        if (!rst && v_o && rdy) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat actual tag=%0h required none", t_o);
            end else begin
                mon_b = exp_q.pop_front();
                chk("beat_tag",  160'(t_o), 160'(mon_b.tag));
                chk("beat_data", 160'(d_o), 160'(mon_b.data));
            end
        end
    end

    // One clock of stimulus: drive, advance the model, then compare registered state.
    task automatic cyc(input bit iss, input logic [TW-1:0] tg, input bit ret, input logic [DW-1:0] d);
        bit    pop, full;
        int    ntags_pre;
        beat_t b;
        issue     = iss;
        tag_i     = tg;
        dv        = ret;
        data_i    = d;
        ntags_pre = mtags.size();
        pop       = rdy && (mdata != 0);
        full      = (mdata == DEPTH);
        if (mtmo == TIMEOUT) e_tmo = 1;
        if (ntags_pre == 0 || ret) mtmo = 0;
        else if (mtmo < TIMEOUT)   mtmo = mtmo + 1;
        if (ret) begin
            if (ntags_pre > 0) b.tag = mtags.pop_front();
            else begin
                b.tag  = '0;
                e_orph = 1;
            end
            b.data = d;
            if (full && !pop) e_ovf = 1;
            else begin
                exp_q.push_back(b);
                mdata++;
            end
        end
        if (iss) mtags.push_back(tg);
        if (pop) mdata--;
        @(posedge clk);
        #1;
        issue = 1'b0;
        dv    = 1'b0;
        chk("outstanding",  160'(outst_o),    160'(mtags.size()));
        chk("rd_ready",     160'(rd_ready_o), 160'(model_ready()));
        chk("out_valid",    160'(v_o),        160'(mdata != 0));
        chk("err_orphan",   160'(orph_o),     160'(e_orph));
        chk("err_overflow", 160'(ovf_o),      160'(e_ovf));
        chk("err_timeout",  160'(tmo_o),      160'(e_tmo));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, '0);
    endtask

    task automatic drain_all();
        rdy = 1'b1;
        for (int i = 0; i < 40 && mtags.size() > 0; i++) cyc(1'b0, '0, 1'b1, rnd128());
        idle(DEPTH + 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] da, db, dc;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid",    160'(v_o),        160'(0));
        chk("rst_outst",    160'(outst_o),    160'(0));
        chk("rst_rd_ready", 160'(rd_ready_o), 160'(1));
        chk("rst_tag",      160'(t_o),        160'(0));
        chk("rst_data",     160'(d_o),        160'(0));
        rst = 1'b0;

        // Three tagged reads, returns two cycles apart, consumer always ready.
        rdy = 1'b1;
        da = {4{32'hAAAA_0001}};
        db = {4{32'hBBBB_0002}};
        dc = {4{32'hCCCC_0003}};
        cyc(1'b1, 4'd3, 1'b0, '0);
        cyc(1'b1, 4'd5, 1'b0, '0);
        cyc(1'b1, 4'd7, 1'b0, '0);
        chk("t1_outst3", 160'(outst_o), 160'(3));
        cyc(1'b0, '0, 1'b1, da);
        chk("t1_first_tag", 160'(t_o), 160'(3));
        chk("t1_first_vld", 160'(v_o), 160'(1));
        idle(1);
        cyc(1'b0, '0, 1'b1, db);
        chk("t1_second_tag", 160'(t_o), 160'(5));
        idle(1);
        cyc(1'b0, '0, 1'b1, dc);
        chk("t1_third_tag", 160'(t_o), 160'(7));
        idle(2);
        chk("t1_outst0", 160'(outst_o), 160'(0));

        // Return with nothing outstanding.
        cyc(1'b0, '0, 1'b1, {4{32'h0BAD_0BAD}});
        chk("orph_tag", 160'(t_o), 160'(0));
        chk("orph_flag", 160'(orph_o), 160'(1));
        chk("orph_no_ovf", 160'(ovf_o), 160'(0));
        idle(3);

        // Fill to capacity with the consumer stalled, then an extra return overflows.
        rdy = 1'b0;
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 4'(i + 8), 1'b0, '0);
        chk("fill_no_credit", 160'(rd_ready_o), 160'(0));
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1, rnd128());
        chk("fill_no_credit2", 160'(rd_ready_o), 160'(0));
        chk("fill_ovf_clear", 160'(ovf_o), 160'(0));
        cyc(1'b0, '0, 1'b1, rnd128());
        chk("ovf_flag", 160'(ovf_o), 160'(1));
        rdy = 1'b1;
        idle(DEPTH + 2);
        chk("drain_credit", 160'(rd_ready_o), 160'(1));

        // Randomised traffic; returns only while something is outstanding.
        for (int i = 0; i < 300; i++) begin
            bit            iss, ret;
            logic [TW-1:0] tg;
            rdy = ($urandom_range(0, 9) < 7);
            iss = model_ready() && ($urandom_range(0, 1) == 1);
            ret = (mtags.size() > 0) && ($urandom_range(0, 9) < 4);
            tg  = 4'($urandom());
            cyc(iss, tg, ret, rnd128());
        end
        drain_all();

        // Oldest read left waiting past the timeout; a late return still pairs normally.
        cyc(1'b1, 4'd1, 1'b0, '0);
        idle(55);
        chk("tmo_not_yet", 160'(tmo_o), 160'(0));
        idle(15);
        chk("tmo_flag", 160'(tmo_o), 160'(1));
        cyc(1'b0, '0, 1'b1, da);
        chk("tmo_late_tag", 160'(t_o), 160'(1));
        idle(3);
        chk("tmo_sticky", 160'(tmo_o), 160'(1));

        // Issue and return in the same cycle with one read outstanding.
        cyc(1'b1, 4'd2, 1'b0, '0);
        idle(1);
        cyc(1'b1, 4'd9, 1'b1, db);
        chk("same_cyc_tag", 160'(t_o), 160'(2));
        chk("same_cyc_outst", 160'(outst_o), 160'(1));
        cyc(1'b0, '0, 1'b1, dc);
        chk("same_cyc_next", 160'(t_o), 160'(9));
        idle(3);

        // Reset with beats buffered and reads outstanding.
        rdy = 1'b0;
        for (int i = 0; i < 6; i++) cyc(1'b1, 4'(i + 1), 1'b0, '0);
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, 1'b1, rnd128());
        chk("pre_rst_outst", 160'(outst_o), 160'(2));
        rst = 1'b1;
        #2;
        chk("mid_rst_valid",    160'(v_o),        160'(0));
        chk("mid_rst_outst",    160'(outst_o),    160'(0));
        chk("mid_rst_rd_ready", 160'(rd_ready_o), 160'(1));
        chk("mid_rst_errs",     160'({orph_o, ovf_o, tmo_o}), 160'(0));
        exp_q.delete();
        mtags.delete();
        mdata  = 0;
        mtmo   = 0;
        e_orph = 0;
        e_ovf  = 0;
        e_tmo  = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rdy = 1'b1;
        cyc(1'b1, 4'hA, 1'b0, '0);
        cyc(1'b1, 4'hB, 1'b0, '0);
        cyc(1'b0, '0, 1'b1, {4{32'h1234_5678}});
        chk("post_rst_tag", 160'(t_o), 160'(4'hA));
        cyc(1'b0, '0, 1'b1, {4{32'h8765_4321}});
        chk("post_rst_tag2", 160'(t_o), 160'(4'hB));
        idle(4);
        chk("scoreboard_empty", 160'(exp_q.size()), 160'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
